// File: rtl/trace_pkg.sv
// trace_pkg: shared types, constants and the frame builder for the retire trace path.
//   TRACE_HDR   - first byte of every frame
//   REC_BYTES   - bytes per frame (14, or 15 with the trailing XOR byte)
//   trace_rec_t - one captured commit {pc, instr, data, rd}
//   state_t     - transmit FSM states
// Optional feature macro: TRACE_CHECKSUM_EN (appends an XOR checksum byte).
package trace_pkg;

  localparam logic [7:0] TRACE_HDR = 8'hA5;

`ifdef TRACE_CHECKSUM_EN
  localparam int REC_BYTES = 15;
`else
  localparam int REC_BYTES = 14;
`endif

  localparam int FRAME_W = REC_BYTES * 8;
  localparam int IDX_W   = $clog2(REC_BYTES);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] data;
    logic [4:0]  rd;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Byte 0 of the frame sits in bits [7:0] so the transmitter can shift right.
  function automatic logic [FRAME_W-1:0] build_frame(input trace_rec_t r);
    logic [FRAME_W-1:0] f;
`ifdef TRACE_CHECKSUM_EN
    logic [7:0] x;
`endif
    f          = '0;
    f[7:0]     = TRACE_HDR;
    f[15:8]    = {3'b000, r.rd};
    f[47:16]   = r.pc;
    f[79:48]   = r.instr;
    f[111:80]  = r.data;
`ifdef TRACE_CHECKSUM_EN
    x = 8'h00;
    for (int i = 0; i < 14; i++) begin
      x = x ^ f[i*8 +: 8];
    end
    f[119:112] = x;
`endif
    return f;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous record FIFO with simultaneous push/pop.
//   clk, reset (async, active-low)
//   push/wdata  - write request; accepted when not full, or when full and
//                 a pop happens on the same edge
//   pop         - remove head (ignored when empty)
//   head        - oldest record; head_next - the record behind it
//   full/empty  - flags from pointers carrying one extra wrap bit
//   count       - number of records held
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           wdata,
  output logic [W-1:0]           head,
  output logic [W-1:0]           head_next,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wptr_q;
  logic [AW:0]   rptr_q;
  logic [W-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;
  logic [AW-1:0] rnext;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count     = wptr_q - rptr_q;
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign rnext     = rptr_q[AW-1:0] + AW'(1);
  assign head      = mem_q[rptr_q[AW-1:0]];
  assign head_next = mem_q[rnext];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/retire_trace_tx.sv
// retire_trace_tx: captures committed register writes from the WB stage and
// serializes each as a fixed-length byte frame on a valid/ready stream.
//   clk, reset (async, active-low)
//   en, wb_pc, wb_instruction, wb_write_data, wb_rd_addr, wb_RegWrite - WB tap
//   tx_data, tx_valid, tx_ready - byte stream
//   overflow (sticky), drop_count (saturating) - lost-record reporting
// Optional feature macro: TRACE_CHECKSUM_EN (15-byte frame with XOR byte).
//
// state | meaning
// IDLE  | no frame on the wire; loads the FIFO head when one is present
// SEND  | frame being shifted out; head is popped on the last byte
module retire_trace_tx
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [31:0]           wb_pc,
  input  logic [31:0]           wb_instruction,
  input  logic [31:0]           wb_write_data,
  input  logic [4:0]            wb_rd_addr,
  input  logic                  wb_RegWrite,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state_q;
  state_t             state_d;
  logic [FRAME_W-1:0] shift_q;
  logic [IDX_W-1:0]   byte_idx_q;

  trace_rec_t         wrec;
  trace_rec_t         head_rec;
  trace_rec_t         next_rec;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CW-1:0]      fifo_count;

  logic               commit;
  logic               pop;
  logic               accept;
  logic               last_byte;
  logic               drop;

  assign commit    = en && wb_RegWrite && (wb_rd_addr != 5'd0);
  assign wrec      = '{pc: wb_pc, instr: wb_instruction, data: wb_write_data, rd: wb_rd_addr};
  assign accept    = (state_q == SEND) && tx_ready;
  assign last_byte = (byte_idx_q == IDX_W'(REC_BYTES - 1));
  assign drop      = commit && fifo_full && !pop;

  assign tx_valid  = (state_q == SEND);
  assign tx_data   = tx_valid ? shift_q[7:0] : 8'h00;

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (commit),
    .pop       (pop),
    .wdata     (wrec),
    .head      (head_rec),
    .head_next (next_rec),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Back-to-back only counts records already stored behind the head; a
  // record pushed on the same edge as the final pop is picked up from IDLE.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = SEND;
      end
      SEND: begin
        if (accept && last_byte) begin
          pop = 1'b1;
          if (fifo_count <= CW'(1)) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shift_q    <= '0;
      byte_idx_q <= '0;
    end else if (state_q == IDLE) begin
      if (!fifo_empty) begin
        shift_q    <= build_frame(head_rec);
        byte_idx_q <= '0;
      end
    end else if (accept) begin
      if (last_byte) begin
        shift_q    <= build_frame(next_rec);
        byte_idx_q <= '0;
      end else begin
        shift_q    <= shift_q >> 8;
        byte_idx_q <= byte_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != '1) drop_count <= drop_count + DROP_CNT_W'(1);
    end
  end

endmodule
